// File: rtl/limber_gnrl_ramsp_arb.sv
// Two-requester arbiter in front of a single-port RAM with a combinational read path.
// Each requester has one registered response slot, and a response is valid one cycle after its request is accepted.
module limber_gnrl_ramsp_arb_rsp #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc,
    input  logic          we,
    input  logic [DW-1:0] ram_dout,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata
);
    // An accept in the same cycle as a retire keeps the slot full with the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (acc) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= we ? '0 : ram_dout;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

module limber_gnrl_ramsp_arb #(
    parameter int DW       = 8,
    parameter int AW       = 6,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    logic [1:0]         req_valid, req_we, rsp_ready, rsp_valid, elig, grant;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata, rsp_rdata;
    logic               last_grant;

    assign req_valid = {req1_valid, req0_valid};
    assign req_we    = {req1_we, req0_we};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A requester may issue only if its response slot is empty or is draining this cycle.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (elig[0] && elig[1]) begin
                if (ARB_MODE == 1 || last_grant) grant[0] = 1'b1;
                else                             grant[1] = 1'b1;
            end else begin
                grant = elig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         last_grant <= 1'b1;
        else if (ARB_MODE == 0 && |grant) last_grant <= grant[1];
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (grant[0]) begin
            ram_we   = req_we[0];
            ram_addr = req_addr[0];
            ram_din  = req_wdata[0];
        end else if (grant[1]) begin
            ram_we   = req_we[1];
            ram_addr = req_addr[1];
            ram_din  = req_wdata[1];
        end
    end
    assign ram_cs = |grant;

    for (genvar n = 0; n < 2; n++) begin : g_rsp
        limber_gnrl_ramsp_arb_rsp #(.DW(DW)) u_rsp (
            .clk       (clk),
            .rst       (rst),
            .acc       (grant[n]),
            .we        (req_we[n]),
            .ram_dout  (ram_dout),
            .rsp_ready (rsp_ready[n]),
            .rsp_valid (rsp_valid[n]),
            .rsp_rdata (rsp_rdata[n])
        );
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_rdata = rsp_rdata[0];
    assign rsp1_rdata = rsp_rdata[1];
endmodule

// File: doc/limber_gnrl_ramsp_arb.md
Name: limber_gnrl_ramsp_arb

Overview:
Two-requester arbiter and sequencer in front of one single-port, no-reset, no-output-register RAM (combinational read, 1-clk write).
- Shares the RAM between requester 0 (e.g. instruction fetch) and requester 1 (e.g. load/store unit).
- Each requester gets a valid/ready request channel and a registered valid/ready response channel.
- At most one RAM access per cycle; one outstanding response per requester.

Parameters:
DW, 8, data width
AW, 6, address width (RAM depth 2**AW)
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 0 highest

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 request accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  AW  request address
req0_wdata  in  DW  write data
rsp0_valid  out  1  requester 0 response valid
rsp0_ready  in  1  requester 0 response consumed
rsp0_rdata  out  DW  read data (0 for write acks)
req1_* / rsp1_*  same set as requester 0, for requester 1
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM combinational read data

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp0_valid = rsp1_valid = 0; rsp0_rdata = rsp1_rdata = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
  - Any in-flight response is discarded.
- Eligibility of requester N: reqN_valid & (~rspN_valid | rspN_ready). The response slot must be free or freeing this cycle.
- Grant, combinational, at most one requester per cycle:
  - Only one requester eligible: grant it.
  - Both eligible, ARB_MODE=0: grant the requester != last_grant.
  - Both eligible, ARB_MODE=1: always grant requester 0.
- reqN_ready = grantN. Never asserted while rst=1. reqN_ready must not depend on reqN_ready/rspN_valid loops beyond the eligibility rule above.
- RAM drive:
  - ram_cs = grant0 | grant1.
  - ram_we, ram_addr, ram_din are muxed from the granted requester.
  - When no grant: ram_cs = 0, ram_we = 0, ram_addr = 0, ram_din = 0.
- Accept cycle (reqN_valid & reqN_ready), updated at the next edge:
  - rspN_valid <= 1.
  - Read: rspN_rdata <= ram_dout, sampled in the same cycle the address is driven.
  - Write: rspN_rdata <= 0.
  - ARB_MODE=0: last_grant <= N.
- Latency: response valid exactly 1 cycle after acceptance. Full throughput is 1 access/cycle across both requesters; each requester alone gets 1/cycle if it keeps rspN_ready=1.
- Response hold: while rspN_valid & ~rspN_ready, rspN_rdata and rspN_valid are stable and requester N is not granted.
- Response retire: rspN_valid & rspN_ready with no new accept for N -> rspN_valid <= 0. Retire plus a new accept in the same cycle -> rspN_valid stays 1 with the new data.
- Read-after-write: a write accepted at cycle t followed by a read of the same address at t+1 (either requester) returns the new data, since the RAM write lands at the edge.
- Same address from both requesters in one cycle: only the granted one proceeds; the other waits and stays unaccepted, and its request fields must be held stable.
- No state machine beyond last_grant and two response registers. No X on any output after reset.

Test Plan:
- Reset then single read: req0 read addr=5 with RAM[5]=8'hA5 -> req0_ready=1 at cycle t, rsp0_valid=1 with rdata=8'hA5 at t+1, ram_cs=1 only at t.
- Write/read-back: req1 write addr=3 data=8'h3C at t, req1 read addr=3 at t+1 -> rsp1 ack rdata=0 at t+1, rsp1 rdata=8'h3C at t+2.
- Round-robin contention (ARB_MODE=0): both requesters read continuously with rspN_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; each requester sees 50% throughput.
- Fixed priority (ARB_MODE=1): both requesters valid for 4 cycles -> req0 granted all 4; req1 granted at the first cycle req0_valid=0.
- Backpressure: rsp0_ready=0 for 3 cycles with a pending rsp0 (rdata=8'h11) -> rsp0_rdata holds 8'h11, req0 not granted, req1 still served each cycle. Raising rsp0_ready with req0 valid retires and accepts in the same cycle.
- Reset mid-operation: assert rst while rsp1_valid=1 and req0 valid -> next edge rsp0_valid=rsp1_valid=0, rdata=0, ram_cs=0 during reset; the first post-reset tie is granted to requester 0.
